// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package ifetch_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned ENTRY_W = 2 * XLEN;

    localparam logic [XLEN-1:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Unsigned compare so a wrapped PC is also caught as out of range.
    function automatic logic pc_in_range(input logic [XLEN-1:0] pc,
                                         input logic [XLEN-1:0] last_adrs);
        return pc <= last_adrs;
    endfunction

endpackage

// File: rtl/ifetch_buf.sv
// DEPTH-entry fetch queue with push/pop/flush; head is presented directly to decode.
module ifetch_buf
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ENTRY_W-1:0] wr_data,
    output logic               head_valid,
    output logic [ENTRY_W-1:0] head_data,
    output logic               full_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt;
    logic               do_push;
    logic               do_pop;

    assign full_c    = (count == CNT_W'(DEPTH));
    assign head_data = mem[rd_ptr];

    // A push into a full queue is legal only when the head leaves the same cycle.
    always_comb begin
        do_pop    = 1'b0;
        do_push   = 1'b0;
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else begin
            do_pop    = pop && (count != '0);
            do_push   = push && (!full_c || do_pop);
            count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            count      <= count_nxt;
            head_valid <= (count_nxt != '0);
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= wr_data;
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: owns the PC, walks instruction memory into the fetch queue,
// and handles redirects, halt detection and out-of-range faults.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 400,
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] imem_adrs,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        dec_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        halted,
    output logic        fault
);

    localparam logic [31:0] LAST_ADRS = 32'(MEM_BYTES - 4);

    state_t       state;
    state_t       state_nxt;
    logic [31:0]  pc;
    logic [31:0]  pc_nxt;
    logic         push_c;
    logic         pop_c;
    logic         flush_c;
    logic         full_c;
    logic         redirect_c;
    fetch_entry_t wr_entry;
    fetch_entry_t head_entry;

    assign imem_adrs  = pc;
    assign wr_entry   = '{instr: imem_data, pc: pc};
    assign inst       = head_entry.instr;
    assign inst_pc    = head_entry.pc;
    assign redirect_c = redirect_valid && (state != ST_IDLE);

    ifetch_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_c),
        .pop        (pop_c),
        .flush      (flush_c),
        .wr_data    (wr_entry),
        .head_valid (inst_valid),
        .head_data  (head_entry),
        .full_c     (full_c)
    );

    // Next state / PC; a redirect overrides everything else that cycle.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        push_c    = 1'b0;
        pop_c     = inst_valid && dec_ready;
        flush_c   = 1'b0;

        if (redirect_c) begin
            flush_c   = 1'b1;
            pop_c     = 1'b0;
            pc_nxt    = redirect_pc;
            state_nxt = (redirect_pc[1:0] != 2'b00) ? ST_FAULT : ST_FETCH;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (!full_c || pop_c) begin
                        if (!pc_in_range(pc, LAST_ADRS)) begin
                            state_nxt = ST_FAULT;
                        end else if (imem_data == HALT_WORD) begin
                            state_nxt = ST_HALT;
                        end else begin
                            push_c = 1'b1;
                            pc_nxt = pc + 32'd4;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            pc     <= RESET_PC;
            halted <= 1'b0;
            fault  <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            halted <= (state_nxt == ST_HALT);
            fault  <= (state_nxt == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: expected deliveries are queued by the stimulus
// and popped by a monitor on every accepted handshake.
module tb_ifetch_ctrl;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] imem_adrs;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        halted;
    logic        fault;

    logic [31:0] mem [100];
    exp_t        exp_q [$];
    int          n_cmp;
    int          n_bad;

    ifetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .imem_adrs      (imem_adrs),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_ready      (dec_ready),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .halted         (halted),
        .fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        imem_data = 32'hBAD0_BAD0;
        if (imem_adrs < 32'd400) begin
            imem_data = mem[imem_adrs[8:2]];
        end
    end

    // Monitor: every accepted head must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && inst_valid && dec_ready && !redirect_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_delivery: got pc=%h inst=%h, required no delivery", inst_pc, inst);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (inst !== e.instr || inst_pc !== e.pc) begin
                    n_bad++;
                    $display("FAIL delivery: got pc=%h inst=%h, required pc=%h inst=%h",
                             inst_pc, inst, e.pc, e.instr);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        start          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;
        exp_q.delete();
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic expect_word(input int idx);
        exp_q.push_back('{instr: mem[idx], pc: 32'(idx * 4)});
    endtask

    task automatic wait_flag(input bit want_fault, input string name);
        int i;
        i = 0;
        while (!(want_fault ? fault : halted) && i < 300) begin
            step();
            i++;
        end
        chk(name, 32'(want_fault ? fault : halted), 32'd1);
    endtask

    task automatic fill(input logic [31:0] base);
        for (int i = 0; i < 100; i++) begin
            mem[i] = base + 32'(i);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        fill(32'h0);
        do_reset();

        // Reset state, then a redirect while IDLE must be ignored
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_adrs", imem_adrs, 32'd0);
        redirect(32'h80);
        chk("idle_redirect_adrs", imem_adrs, 32'd0);
        chk("idle_redirect_valid", 32'(inst_valid), 32'd0);

        // 1: streaming A..D then halt word
        mem[0] = 32'hAAAA_0001; mem[1] = 32'hBBBB_0002;
        mem[2] = 32'hCCCC_0003; mem[3] = 32'hDDDD_0004; mem[4] = HALTW;
        for (int i = 0; i < 4; i++) expect_word(i);
        dec_ready = 1'b1;
        kick();
        chk("t1_latency_n", 32'(inst_valid), 32'd0);
        step();
        chk("t1_first_valid", 32'(inst_valid), 32'd1);
        chk("t1_first_pc", inst_pc, 32'd0);
        step();
        chk("t1_second_pc", inst_pc, 32'd4);
        wait_flag(1'b0, "t1_halted");
        step();
        chk("t1_drained", 32'(exp_q.size()), 32'd0);

        // 2: backpressure holds exactly DEPTH entries, release loses nothing
        fill(32'h2000_0000);
        mem[8] = HALTW;
        do_reset();
        kick();
        repeat (5) step();
        chk("t2_valid", 32'(inst_valid), 32'd1);
        chk("t2_head_pc", inst_pc, 32'd0);
        chk("t2_adrs", imem_adrs, 32'd8);
        for (int i = 0; i < 8; i++) expect_word(i);
        dec_ready = 1'b1;
        wait_flag(1'b0, "t2_halted");
        step();
        chk("t2_drained", 32'(exp_q.size()), 32'd0);
        chk("t2_halt_adrs", imem_adrs, 32'd32);

        // 3: redirect with a full queue flushes stale words
        fill(32'h3000_0000);
        mem[19] = HALTW;
        do_reset();
        kick();
        repeat (4) step();
        chk("t3_full_adrs", imem_adrs, 32'd8);
        redirect(32'h40);
        chk("t3_flushed", 32'(inst_valid), 32'd0);
        chk("t3_redir_adrs", imem_adrs, 32'h40);
        step();
        chk("t3_new_valid", 32'(inst_valid), 32'd1);
        chk("t3_new_pc", inst_pc, 32'h40);
        chk("t3_new_inst", inst, 32'h3000_0010);
        for (int i = 16; i < 19; i++) expect_word(i);
        dec_ready = 1'b1;
        wait_flag(1'b0, "t3_halted");
        step();
        chk("t3_drained", 32'(exp_q.size()), 32'd0);

        // 4: halt at 0x0C, then redirect out of HALT
        fill(32'h4000_0000);
        mem[3]  = HALTW;
        mem[10] = HALTW;
        do_reset();
        for (int i = 0; i < 3; i++) expect_word(i);
        dec_ready = 1'b1;
        kick();
        wait_flag(1'b0, "t4_halted");
        step();
        chk("t4_drained", 32'(exp_q.size()), 32'd0);
        chk("t4_empty", 32'(inst_valid), 32'd0);
        chk("t4_pc_held", imem_adrs, 32'h0C);
        expect_word(8);
        expect_word(9);
        redirect(32'h20);
        chk("t4_unhalted", 32'(halted), 32'd0);
        chk("t4_resume_adrs", imem_adrs, 32'h20);
        wait_flag(1'b0, "t4_halted_again");
        step();
        chk("t4_drained_again", 32'(exp_q.size()), 32'd0);
        chk("t4_second_halt_adrs", imem_adrs, 32'h28);

        // 5: run off the end of memory, then a misaligned redirect
        fill(32'h5000_0000);
        do_reset();
        for (int i = 0; i < 100; i++) expect_word(i);
        dec_ready = 1'b1;
        kick();
        wait_flag(1'b1, "t5_fault");
        step();
        chk("t5_drained", 32'(exp_q.size()), 32'd0);
        chk("t5_not_halted", 32'(halted), 32'd0);
        chk("t5_fault_adrs", imem_adrs, 32'd400);
        dec_ready = 1'b0;
        redirect(32'h0);
        chk("t5_fault_cleared", 32'(fault), 32'd0);
        repeat (3) step();
        chk("t5_refilled", 32'(inst_valid), 32'd1);
        redirect(32'h22);
        chk("t5_misalign_fault", 32'(fault), 32'd1);
        chk("t5_misalign_flush", 32'(inst_valid), 32'd0);
        chk("t5_misalign_adrs", imem_adrs, 32'h22);

        // 6: asynchronous reset mid-stream
        fill(32'h6000_0000);
        do_reset();
        kick();
        repeat (3) step();
        chk("t6_pre_valid", 32'(inst_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(inst_valid), 32'd0);
        chk("t6_async_inst", inst, 32'd0);
        chk("t6_async_inst_pc", inst_pc, 32'd0);
        chk("t6_async_halted", 32'(halted), 32'd0);
        chk("t6_async_fault", 32'(fault), 32'd0);
        chk("t6_async_adrs", imem_adrs, 32'd0);
        step();
        rst_n = 1'b1;
        repeat (2) step();
        chk("t6_idle_valid", 32'(inst_valid), 32'd0);
        chk("t6_idle_adrs", imem_adrs, 32'd0);
        kick();
        step();
        chk("t6_restart_valid", 32'(inst_valid), 32'd1);
        chk("t6_restart_pc", inst_pc, 32'd0);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
